// File: rtl/status_value_reader.sv
// Pull-side controller for the status value vector: tracks occupancy, issues pulls,
// and holds the head bit in a one-entry valid/ready output stage.
module status_value_reader #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic             vec_push_i,
    input  logic             vec_head_i,
    output logic             vec_pull_o,
    output logic             vec_empty_o,
    output logic             vec_full_o,
    output logic [CNT_W-1:0] count_o,
    output logic             rd_valid_o,
    output logic             rd_data_o,
    input  logic             rd_ready_i,
    input  logic             flush_i,
    output logic             overflow_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_data_q, rd_data_d;
    logic             overflow_q, overflow_d;
    logic             stage_free;
    logic             pull;
    logic             push;

    // Pull is a function of registered state, ready and flush only; never of the push strobe.
    assign stage_free = ~rd_valid_q | rd_ready_i;
    assign pull       = (count_q != '0) & stage_free & ~flush_i;
    assign push       = vec_push_i & (~full_q | pull);

    always_comb begin
        count_d    = count_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        overflow_d = overflow_q;

        if (flush_i) begin
            count_d    = '0;
            rd_valid_d = 1'b0;
            overflow_d = 1'b0;
        end else begin
            if (push && !pull) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push && pull) begin
                count_d = count_q - CNT_W'(1);
            end

            if (vec_push_i && full_q && !pull) begin
                overflow_d = 1'b1;
            end

            if (pull) begin
                rd_data_d  = vec_head_i;
                rd_valid_d = 1'b1;
            end else if (rd_ready_i && rd_valid_q) begin
                rd_valid_d = 1'b0;
            end
        end

        // Flags follow the next count so they never lag the counter.
        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            overflow_q <= overflow_d;
        end
    end

    // Gate the pull with reset so the vector never shifts while reset is held.
    assign vec_pull_o  = pull & arst_n_i;
    assign vec_empty_o = empty_q;
    assign vec_full_o  = full_q;
    assign count_o     = count_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_status_value_reader.sv
// Bench for status_value_reader: a queue-based model of vector plus output stage,
// checked every cycle, with literal expectations for the directed scenarios.
module tb_status_value_reader;
    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk_i = 1'b0;
    logic             arst_n_i;
    logic             vec_push_i;
    logic             vec_head_i;
    logic             vec_pull_o;
    logic             vec_empty_o;
    logic             vec_full_o;
    logic [CNT_W-1:0] count_o;
    logic             rd_valid_o;
    logic             rd_data_o;
    logic             rd_ready_i;
    logic             flush_i;
    logic             overflow_o;

    int errors = 0;
    int checks = 0;

    // Model: the vector is a queue of bits; the output stage is valid/data; overflow is sticky.
    bit mq[$];
    bit m_valid, m_data, m_ovf;

    always #5 clk_i = ~clk_i;

    status_value_reader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i      (clk_i),
        .arst_n_i   (arst_n_i),
        .vec_push_i (vec_push_i),
        .vec_head_i (vec_head_i),
        .vec_pull_o (vec_pull_o),
        .vec_empty_o(vec_empty_o),
        .vec_full_o (vec_full_o),
        .count_o    (count_o),
        .rd_valid_o (rd_valid_o),
        .rd_data_o  (rd_data_o),
        .rd_ready_i (rd_ready_i),
        .flush_i    (flush_i),
        .overflow_o (overflow_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_valid = 1'b0;
        m_data  = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare DUT against the model, then advance the model.
    task automatic step(input bit push, input bit val, input bit rdy, input bit fl);
        bit m_pull, m_push, m_full;
        @(negedge clk_i);
        vec_push_i = push;
        rd_ready_i = rdy;
        flush_i    = fl;
        vec_head_i = (mq.size() != 0) ? mq[0] : 1'b0;
        #1;
        m_full = (mq.size() == DEPTH);
        m_pull = (mq.size() != 0) && (!m_valid || rdy) && !fl;
        m_push = push && (!m_full || m_pull);
        chk("count", 32'(count_o), 32'(mq.size()));
        chk("empty", 32'(vec_empty_o), 32'(mq.size() == 0));
        chk("full", 32'(vec_full_o), 32'(m_full));
        chk("valid", 32'(rd_valid_o), 32'(m_valid));
        chk("data", 32'(rd_data_o), 32'(m_data));
        chk("overflow", 32'(overflow_o), 32'(m_ovf));
        chk("pull", 32'(vec_pull_o), 32'(m_pull));
        @(posedge clk_i);
        if (fl) begin
            mq.delete();
            m_valid = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            if (push && m_full && !m_pull) m_ovf = 1'b1;
            if (m_pull) begin
                m_data  = mq.pop_front();
                m_valid = 1'b1;
            end else if (rdy && m_valid) begin
                m_valid = 1'b0;
            end
            if (m_push) mq.push_back(val);
        end
        #2;
    endtask

    initial begin
        arst_n_i   = 1'b0;
        vec_push_i = 1'b0;
        vec_head_i = 1'b0;
        rd_ready_i = 1'b0;
        flush_i    = 1'b0;
        model_clear();
        #12;
        chk("rst_count", 32'(count_o), 0);
        chk("rst_empty", 32'(vec_empty_o), 1);
        chk("rst_valid", 32'(rd_valid_o), 0);
        chk("rst_pull", 32'(vec_pull_o), 0);
        @(negedge clk_i);
        arst_n_i = 1'b1;

        // Three pushes 1,0,1 with ready high: delivered on consecutive cycles.
        step(1, 1, 1, 0);
        step(1, 0, 1, 0);
        chk("t1_valid0", 32'(rd_valid_o), 1);
        chk("t1_data0", 32'(rd_data_o), 1);
        step(1, 1, 1, 0);
        chk("t1_data1", 32'(rd_data_o), 0);
        step(0, 0, 1, 0);
        chk("t1_data2", 32'(rd_data_o), 1);
        chk("t1_count", 32'(count_o), 0);
        chk("t1_empty", 32'(vec_empty_o), 1);
        step(0, 0, 1, 0);
        chk("t1_drained", 32'(rd_valid_o), 0);

        // Fill with the stage stalled, then overflow.
        for (int i = 0; i < 8; i++) step(1, i[0], 0, 0);
        chk("t2_count7", 32'(count_o), 7);
        step(1, 1, 0, 0);
        chk("t2_count8", 32'(count_o), 8);
        chk("t2_full", 32'(vec_full_o), 1);
        chk("t2_noovf", 32'(overflow_o), 0);
        step(1, 0, 0, 0);
        chk("t2_ovf", 32'(overflow_o), 1);
        chk("t2_stay8", 32'(count_o), 8);
        // Push and pull together while full.
        step(1, 1, 1, 0);
        chk("t3_count8", 32'(count_o), 8);
        chk("t3_data", 32'(rd_data_o), 1);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0);

        // Ready toggling over six entries.
        step(0, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(1, (i % 3) == 1, i[0], 0);
        for (int i = 0; i < 12; i++) step(0, 0, i[0], 0);

        // Flush with coincident push while count 5 and stage valid.
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0);
        chk("t5_count5", 32'(count_o), 5);
        step(1, 0, 1, 1);
        chk("t5_count0", 32'(count_o), 0);
        chk("t5_valid0", 32'(rd_valid_o), 0);
        chk("t5_ovf0", 32'(overflow_o), 0);

        // Asynchronous reset mid-stream at count 4.
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        chk("t6_count4", 32'(count_o), 4);
        @(negedge clk_i);
        vec_push_i = 1'b0;
        rd_ready_i = 1'b1;
        arst_n_i   = 1'b0;
        #1;
        chk("t6_rst_count", 32'(count_o), 0);
        chk("t6_rst_valid", 32'(rd_valid_o), 0);
        chk("t6_rst_empty", 32'(vec_empty_o), 1);
        chk("t6_rst_pull", 32'(vec_pull_o), 0);
        model_clear();
        @(negedge clk_i);
        arst_n_i = 1'b1;
        step(1, 1, 1, 0);
        step(0, 0, 1, 0);
        chk("t6_deliver_valid", 32'(rd_valid_o), 1);
        chk("t6_deliver_data", 32'(rd_data_o), 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 60, 1'($urandom), $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
